// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window controller and its datapath.
package sobel_pkg;

  localparam int unsigned PIX_W = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StDone   = 2'd2
  } sobel_state_e;

  // Window tap indices for the eight neighbours; the centre pixel has no tap.
  localparam int unsigned TapP0   = 0;
  localparam int unsigned TapP1   = 1;
  localparam int unsigned TapP2   = 2;
  localparam int unsigned TapP3   = 3;
  localparam int unsigned TapP4   = 4;
  localparam int unsigned TapP5   = 5;
  localparam int unsigned TapP6   = 6;
  localparam int unsigned TapP7   = 7;
  localparam int unsigned NumTaps = 8;

endpackage

// File: rtl/core_sobel.sv
// Combinational Sobel magnitude |gx|+|gy| over eight neighbours, saturated to 8 bits.
module core_sobel
  import sobel_pkg::*;
(
  input  logic [PIX_W-1:0] p0_i,
  input  logic [PIX_W-1:0] p1_i,
  input  logic [PIX_W-1:0] p2_i,
  input  logic [PIX_W-1:0] p3_i,
  input  logic [PIX_W-1:0] p4_i,
  input  logic [PIX_W-1:0] p5_i,
  input  logic [PIX_W-1:0] p6_i,
  input  logic [PIX_W-1:0] p7_i,
  output logic [PIX_W-1:0] mag_o
);

  logic signed [10:0] e0, e1, e2, e3, e4, e5, e6, e7;
  logic signed [10:0] gx, gy;
  logic        [10:0] ax, ay, sum;

  always_comb begin
    e0  = signed'({3'b000, p0_i});
    e1  = signed'({3'b000, p1_i});
    e2  = signed'({3'b000, p2_i});
    e3  = signed'({3'b000, p3_i});
    e4  = signed'({3'b000, p4_i});
    e5  = signed'({3'b000, p5_i});
    e6  = signed'({3'b000, p6_i});
    e7  = signed'({3'b000, p7_i});
    // Right column minus left column, bottom row minus top row.
    gx  = (e2 + (e4 <<< 1) + e7) - (e0 + (e3 <<< 1) + e5);
    gy  = (e5 + (e6 <<< 1) + e7) - (e0 + (e1 <<< 1) + e2);
    ax  = gx[10] ? $unsigned(-gx) : $unsigned(gx);
    ay  = gy[10] ? $unsigned(-gy) : $unsigned(gy);
    sum = ax + ay;
    mag_o = (sum > 11'd255) ? 8'hFF : sum[7:0];
  end

endmodule

// File: rtl/sobel_line_buf.sv
// Single-row pixel buffer with combinational read-before-write at one address.
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int unsigned Depth = 640,
  parameter int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [PIX_W-1:0] wdata_i,
  output logic [PIX_W-1:0] rdata_o
);

  logic [PIX_W-1:0] mem_q [Depth];

  assign rdata_o = mem_q[addr_i];

  // Contents are not reset: every frame rewrites a row before it is read.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Streaming 3x3 window controller feeding core_sobel; one registered result per interior pixel.
// Optional binarized output enabled by defining SOBEL_THRESH_EN (adds the thresh port).
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_eol,
  output logic             out_eof,
  output logic             busy,
  output logic             done
`ifdef SOBEL_THRESH_EN
  ,
  input  logic [PIX_W-1:0] thresh
`endif
);

  localparam int unsigned AddrW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  sobel_state_e state_q, state_d;

  logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
  logic             last_in_q, last_in_d;

  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_pixel_q, out_pixel_d;
  logic             out_eol_q, out_eol_d;
  logic             out_eof_q, out_eof_d;

  // Columns c-1 and c-2 of rows r-2 (top), r-1 (mid) and r (bot).
  logic [PIX_W-1:0] top_c1_q, top_c2_q, mid_c1_q, mid_c2_q, bot_c1_q, bot_c2_q;

  logic [PIX_W-1:0] buf_a_rd, buf_b_rd;
  logic [PIX_W-1:0] win [NumTaps];
  logic [PIX_W-1:0] mag, result;

  logic accept, emit, out_hs, col_last, row_last;

  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;
  assign col_last = (col_q == CNT_W'(IMG_W - 1));
  assign row_last = (row_q == CNT_W'(IMG_H - 1));
  assign emit     = accept && (row_q >= CNT_W'(2)) && (col_q >= CNT_W'(2));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StStream;
      StStream: if (out_hs && out_eof_q) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    busy     = (state_q == StStream) || (state_q == StDone);
    done     = (state_q == StDone);
    in_ready = (state_q == StStream) && !last_in_q && (out_ready || !out_valid_q);
  end

  // ---------------------------------------------------------- counters
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    last_in_d = last_in_q;
    if ((state_q == StIdle) && start) begin
      col_d     = '0;
      row_d     = '0;
      last_in_d = 1'b0;
    end else if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_q + CNT_W'(1);
        if (row_last) last_in_d = 1'b1;
      end else begin
        col_d = col_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      last_in_q <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      last_in_q <= last_in_d;
    end
  end

  // ------------------------------------------------------ line buffers
  // A holds row r-1; its old entry shifts into B, which then holds row r-2.
  sobel_line_buf #(
    .Depth (IMG_W),
    .AddrW (AddrW)
  ) u_buf_a (
    .clk_i   (clk),
    .we_i    (accept),
    .addr_i  (col_q[AddrW-1:0]),
    .wdata_i (in_pixel),
    .rdata_o (buf_a_rd)
  );

  sobel_line_buf #(
    .Depth (IMG_W),
    .AddrW (AddrW)
  ) u_buf_b (
    .clk_i   (clk),
    .we_i    (accept),
    .addr_i  (col_q[AddrW-1:0]),
    .wdata_i (buf_a_rd),
    .rdata_o (buf_b_rd)
  );

  // Stale values across a row wrap are harmless: no output for c < 2.
  always_ff @(posedge clk) begin
    if (accept) begin
      top_c1_q <= buf_b_rd;
      top_c2_q <= top_c1_q;
      mid_c1_q <= buf_a_rd;
      mid_c2_q <= mid_c1_q;
      bot_c1_q <= in_pixel;
      bot_c2_q <= bot_c1_q;
    end
  end

  // ----------------------------------------------------------- window
  always_comb begin
    win[TapP0] = top_c2_q;
    win[TapP1] = top_c1_q;
    win[TapP2] = buf_b_rd;
    win[TapP3] = mid_c2_q;
    win[TapP4] = buf_a_rd;
    win[TapP5] = bot_c2_q;
    win[TapP6] = bot_c1_q;
    win[TapP7] = in_pixel;
  end

  core_sobel u_core (
    .p0_i  (win[TapP0]),
    .p1_i  (win[TapP1]),
    .p2_i  (win[TapP2]),
    .p3_i  (win[TapP3]),
    .p4_i  (win[TapP4]),
    .p5_i  (win[TapP5]),
    .p6_i  (win[TapP6]),
    .p7_i  (win[TapP7]),
    .mag_o (mag)
  );

`ifdef SOBEL_THRESH_EN
  assign result = (mag >= thresh) ? 8'hFF : 8'h00;
`else
  assign result = mag;
`endif

  // ---------------------------------------------------- output register
  always_comb begin
    out_valid_d = out_valid_q;
    out_pixel_d = out_pixel_q;
    out_eol_d   = out_eol_q;
    out_eof_d   = out_eof_q;
    if (emit) begin
      out_valid_d = 1'b1;
      out_pixel_d = result;
      out_eol_d   = col_last;
      out_eof_d   = col_last && row_last;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
      out_eol_d   = 1'b0;
      out_eof_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      out_eol_q   <= out_eol_d;
      out_eof_q   <= out_eof_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign out_eol   = out_eol_q;
  assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl on a 4x4 frame; define SOBEL_THRESH_EN for the threshold case.
module tb_sobel_window_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_pixel = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_pixel;
  logic       out_eol, out_eof, busy, done;
`ifdef SOBEL_THRESH_EN
  logic [7:0] thresh = 8'd0;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] got_pix [$];
  logic       got_eol [$];
  logic       got_eof [$];
  int done_cnt, acc_cnt, bubbles, stall_ready_bad, stall_pix_bad;
  int first_out_idx, eof_cyc, done_cyc, timed_out;

  always #5 clk = ~clk;

  sobel_window_ctrl #(
    .IMG_W (4),
    .IMG_H (4),
    .CNT_W (12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pixel (out_pixel),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .busy      (busy),
    .done      (done)
`ifdef SOBEL_THRESH_EN
    ,
    .thresh    (thresh)
`endif
  );

  // 0: flat 100, 1: horizontal ramp 10*c, 2: vertical step at row 2.
  function automatic logic [7:0] pix_of(input int pat, input int idx);
    case (pat)
      0:       return 8'd100;
      1:       return 8'(10 * (idx % 4));
      default: return ((idx / 4) < 2) ? 8'd0 : 8'd200;
    endcase
  endfunction

  task automatic drive_frame(input int pat, input int stall_len, input int max_acc);
    int idx, cyc, stall_left, post_done;
    bit seen_first;
    logic [7:0] ref_pix;
    got_pix.delete(); got_eol.delete(); got_eof.delete();
    done_cnt = 0; acc_cnt = 0; bubbles = 0; stall_ready_bad = 0; stall_pix_bad = 0;
    first_out_idx = -1; eof_cyc = -100; done_cyc = -1; timed_out = 0;
    idx = 0; cyc = 0; stall_left = 0; post_done = 0; seen_first = 0; ref_pix = 8'd0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !seen_first) begin
        seen_first = 1; first_out_idx = idx; stall_left = stall_len; ref_pix = out_pixel;
      end
      out_ready = (stall_left == 0);
      in_valid  = (idx < max_acc);
      in_pixel  = pix_of(pat, idx);
      #1;
      if (stall_left > 0) begin
        if (in_ready) stall_ready_bad++;
        if (!out_valid || out_pixel !== ref_pix) stall_pix_bad++;
        stall_left--;
      end else if (in_valid && !in_ready) begin
        bubbles++;
      end
      if (out_valid && out_ready) begin
        got_pix.push_back(out_pixel); got_eol.push_back(out_eol); got_eof.push_back(out_eof);
        if (out_eof) eof_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (in_valid && in_ready) idx++;
      acc_cnt = idx;
      cyc++;
      if (done_cnt > 0) post_done++;
      if (max_acc < 16 && idx == max_acc) begin
        @(posedge clk); #1;
        break;
      end
      if (post_done > 2) break;
      if (cyc > 200) begin timed_out = 1; break; end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_valid, out_eol, out_eof, busy, done, in_ready} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000000",
                      {out_valid, out_eol, out_eof, busy, done, in_ready});
    end
    total++;
    if (out_pixel !== 8'd0) begin bad++; $display("FAIL reset_pix: got %0d want 0", out_pixel); end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL idle_no_ready: got %b want 0", in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_flat();
    logic exp_eol [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic exp_eof [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    drive_frame(0, 0, 16);
    total++;
    if (timed_out != 0) begin bad++; $display("FAIL flat_timeout: got %0d want 0", timed_out); end
    total++;
    if (got_pix.size() != 4) begin bad++; $display("FAIL flat_count: got %0d want 4", got_pix.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (got_pix[k] !== 8'd0) begin bad++; $display("FAIL flat_pix[%0d]: got %0d want 0", k, got_pix[k]); end
        total++;
        if (got_eol[k] !== exp_eol[k] || got_eof[k] !== exp_eof[k]) begin
          bad++; $display("FAIL flat_marks[%0d]: got eol=%b eof=%b want eol=%b eof=%b",
                          k, got_eol[k], got_eof[k], exp_eol[k], exp_eof[k]);
        end
      end
    end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL flat_done_cnt: got %0d want 1", done_cnt); end
    total++;
    if (done_cyc - eof_cyc != 1) begin
      bad++; $display("FAIL flat_done_timing: got %0d want 1", done_cyc - eof_cyc);
    end
    total++;
    if (acc_cnt != 16) begin bad++; $display("FAIL flat_accepts: got %0d want 16", acc_cnt); end
    total++;
    if (bubbles != 0) begin bad++; $display("FAIL flat_bubbles: got %0d want 0", bubbles); end
    total++;
    if (first_out_idx != 11) begin bad++; $display("FAIL flat_latency: got %0d want 11", first_out_idx); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL flat_idle_after: got busy=%b want 0", busy); end
  endtask

  task automatic test_ramp();
    drive_frame(1, 0, 16);
    total++;
    if (got_pix.size() != 4) begin bad++; $display("FAIL ramp_count: got %0d want 4", got_pix.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (got_pix[k] !== 8'd80) begin bad++; $display("FAIL ramp_pix[%0d]: got %0d want 80", k, got_pix[k]); end
      end
    end
  endtask

  task automatic test_vstep();
    drive_frame(2, 0, 16);
    total++;
    if (got_pix.size() != 4) begin bad++; $display("FAIL vstep_count: got %0d want 4", got_pix.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (got_pix[k] !== 8'd255) begin bad++; $display("FAIL vstep_pix[%0d]: got %0d want 255", k, got_pix[k]); end
      end
    end
  endtask

  task automatic test_backpressure();
    drive_frame(1, 5, 16);
    total++;
    if (stall_ready_bad != 0) begin bad++; $display("FAIL bp_in_ready: got %0d want 0", stall_ready_bad); end
    total++;
    if (stall_pix_bad != 0) begin bad++; $display("FAIL bp_hold: got %0d want 0", stall_pix_bad); end
    total++;
    if (got_pix.size() != 4) begin bad++; $display("FAIL bp_count: got %0d want 4", got_pix.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (got_pix[k] !== 8'd80) begin bad++; $display("FAIL bp_pix[%0d]: got %0d want 80", k, got_pix[k]); end
      end
      total++;
      if (got_eof[3] !== 1'b1) begin bad++; $display("FAIL bp_eof: got %b want 1", got_eof[3]); end
    end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL bp_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_midframe_reset();
    drive_frame(0, 0, 7);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    @(negedge clk); rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({out_valid, out_eol, out_eof, busy, done, in_ready} !== 6'b0 || out_pixel !== 8'd0) begin
      bad++; $display("FAIL mid_reset: got ctrl=%b pix=%0d want ctrl=000000 pix=0",
                      {out_valid, out_eol, out_eof, busy, done, in_ready}, out_pixel);
    end
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    drive_frame(0, 0, 16);
    total++;
    if (got_pix.size() != 4) begin bad++; $display("FAIL mid_count: got %0d want 4", got_pix.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (got_pix[k] !== 8'd0) begin bad++; $display("FAIL mid_pix[%0d]: got %0d want 0", k, got_pix[k]); end
      end
    end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL mid_done_cnt: got %0d want 1", done_cnt); end
  endtask

`ifdef SOBEL_THRESH_EN
  task automatic test_thresh();
    logic [7:0] th [2]  = '{8'd81, 8'd80};
    logic [7:0] exp [2] = '{8'd0, 8'd255};
    for (int t = 0; t < 2; t++) begin
      thresh = th[t];
      drive_frame(1, 0, 16);
      total++;
      if (got_pix.size() != 4) begin bad++; $display("FAIL th_count: got %0d want 4", got_pix.size()); end
      else begin
        for (int k = 0; k < 4; k++) begin
          total++;
          if (got_pix[k] !== exp[t]) begin
            bad++; $display("FAIL th%0d_pix[%0d]: got %0d want %0d", th[t], k, got_pix[k], exp[t]);
          end
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_flat();
    test_ramp();
    test_vstep();
    test_backpressure();
    test_midframe_reset();
`ifdef SOBEL_THRESH_EN
    test_thresh();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sobel_window_ctrl.md
# sobel_window_ctrl

Streaming controller that sequences the combinational Sobel magnitude datapath (`core_sobel`) over a raster-scanned 8-bit grayscale frame. It accepts one pixel per cycle over a valid/ready handshake and keeps two line buffers. It assembles each 3x3 neighbourhood, drives the datapath's eight neighbour inputs, and emits one registered edge-magnitude pixel per interior position, with end-of-line and end-of-frame markers. It sits between the pixel source (camera/DMA reader) and the result sink.

## Interface
- IMG_W, 640: frame width in pixels (>= 3).
- IMG_H, 480: frame height in pixels (>= 3).
- CNT_W, 12: width of the row and column counters (must hold max(IMG_W, IMG_H)).
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse in IDLE begins a frame; ignored otherwise.
- in_valid  in  1  source has a pixel.
- in_ready  out  1  controller accepts a pixel this cycle.
- in_pixel  in  8  input pixel, raster order.
- out_valid  out  1  out_pixel is valid.
- out_ready  in  1  sink accepts the output.
- out_pixel  out  8  saturated edge magnitude |gx|+|gy|, clipped to 255.
- out_eol  out  1  qualifies the last output of an output row.
- out_eof  out  1  qualifies the last output of the frame.
- busy  out  1  high in STREAM and DONE.
- done  out  1  one-cycle pulse after the final output handshake.
- thresh  in  8  binarization threshold; present only with SOBEL_THRESH_EN.

## Operation
- FSM states and transitions:
  - IDLE to STREAM on `start`; clears the row/col counters.
  - STREAM to DONE when the last output (eof) handshakes.
  - DONE to IDLE unconditionally after 1 cycle; `done` is high in DONE.
- Input accept: `in_ready = (state==STREAM) && !last_in_taken && (out_ready || !out_valid)`. A pixel is accepted when `in_valid && in_ready`.
- Counters: col increments per accepted pixel and wraps from IMG_W-1 to 0, incrementing row. After pixel (IMG_H-1, IMG_W-1), `last_in_taken` is set and no further pixels are accepted.
- Line buffers: two IMG_W x 8 buffers (rows r-1, r-2), indexed by col. On each accept, the pixel is written to buffer A, and A's old content moves to buffer B. Column shift registers hold columns c-1 and c-2 of all three rows.
- Window mapping for core_sobel, with the window centred at (r-1, c-1):
  - p0 = (r-2, c-2), p1 = (r-2, c-1), p2 = (r-2, c).
  - p3 = (r-1, c-2), p4 = (r-1, c).
  - p5 = (r, c-2), p6 = (r, c-1), p7 = (r, c).
  - The centre pixel is unused.
- Emission: accepting pixel (r, c) with r >= 2 and c >= 2 produces an output. Total outputs are (IMG_W-2) x (IMG_H-2).
  - `out_eol` is set when c == IMG_W-1.
  - `out_eof` is set when, in addition, r == IMG_H-1.
- Arithmetic is inside core_sobel: 11-bit signed gradients, 11-bit sum, saturation to 8'hFF.
- Reset (including mid-frame) forces:
  - state IDLE;
  - counters 0 and `last_in_taken` 0;
  - `in_ready`, `out_valid`, `out_eol`, `out_eof`, `busy`, `done` all 0;
  - `out_pixel` 0.
  - Line-buffer contents are not cleared; they are don't-care because every frame rewrites them before use.

## Timing
- Latency is 1 cycle: `out_valid` rises on the clock edge that accepts pixel (r, c) for an interior position.
- `out_valid`, `out_pixel`, `out_eol` and `out_eof` are registered. They hold stable while `out_valid && !out_ready`. While stalled, `in_ready` is low, so no pixel is lost or overwritten.
- Simultaneous output handshake and new qualifying accept: the output register reloads in the same cycle, giving full throughput of 1 pixel/cycle.
- Non-emitting accepts (r < 2 or c < 2) proceed while a previous output is pending only if `out_ready` is high, per the `in_ready` rule.
- `done` is high exactly one cycle after the eof handshake.
- `start` during STREAM or DONE is ignored.

## Configuration
- Macro: SOBEL_THRESH_EN.
- Defined: adds the `thresh` port. `out_pixel` = (mag >= thresh) ? 8'hFF : 8'h00, where `thresh` is sampled on each output-register load.
- Undefined: no `thresh` port; `out_pixel` = saturated magnitude.

## Structure
- Shared package `sobel_pkg` holds:
  - PIX_W = 8;
  - the FSM state enum (IDLE, STREAM, DONE);
  - localparams for the window tap indices p0–p7.
- Sub-module `sobel_line_buf` implements a single IMG_W x 8 read-before-write buffer and is instantiated twice.
- The existing core_sobel is instantiated once, unmodified.

## Test plan
All scenarios use IMG_W = IMG_H = 4.
- Flat frame, all pixels 100, out_ready = 1: 4 outputs all 0. eol on outputs 2 and 4, eof on output 4. `done` pulses once. 16 input cycles in total.
- Horizontal ramp, pixel = 10*c: 4 outputs all 80 (gx = 20+40+20, gy = 0).
- Vertical step (rows 0–1 = 0, rows 2–3 = 200): 4 outputs all 255 (gy saturates).
- Backpressure: ramp frame with out_ready held low 5 cycles after the first output. `out_pixel` stays 80, `in_ready` stays low, and all 4 outputs arrive intact.
- Reset asserted after 7 accepted pixels: next cycle state is IDLE and all outputs are 0. A new `start` plus a flat frame then gives 4 zero outputs.
- With SOBEL_THRESH_EN, ramp frame: thresh = 81 gives 4 outputs of 0; thresh = 80 gives 4 outputs of 255.
